// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-bus signals of the IF/MEM bus arbiter.
// master: arbiter view (drives acks, read data and the bus request side).
// slave : environment view (pipeline requesters plus the memory bus).
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_data_o;
  logic              if_ack_o;

  logic              mem_req_i;
  logic              mem_we_i;
  logic [3:0]        mem_sel_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic [DATA_W-1:0] mem_rdata_o;
  logic              mem_ack_o;

  logic              bus_req_o;
  logic              bus_we_o;
  logic [3:0]        bus_sel_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic [DATA_W-1:0] bus_rdata_i;
  logic              bus_ack_i;

  modport master (
    input  if_req_i, if_addr_i,
    input  mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    input  bus_rdata_i, bus_ack_i,
    output if_data_o, if_ack_o, mem_rdata_o, mem_ack_o,
    output bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o
  );

  modport slave (
    output if_req_i, if_addr_i,
    output mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    output bus_rdata_i, bus_ack_i,
    input  if_data_o, if_ack_o, mem_rdata_o, mem_ack_o,
    input  bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory bus between instruction fetch
// and the MEM-stage data access. MEM has fixed priority (older instruction).
// Optional bus-wait timeout enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  mem_arbiter_if.master       io,
  output logic [5:0]          stall_o,
  output logic                err_o
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must be within 1..255");
  end

  typedef enum logic [1:0] {IDLE, BUS_IF, BUS_MEM, DONE} state_t;

  state_t            state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [3:0]        bus_sel_q, bus_sel_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              mem_ack_q, mem_ack_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              owner_if;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d;
`endif

  assign owner_if = (state_q == BUS_IF);

  // Next-state and next-value logic for every registered output.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
`ifdef ARB_TIMEOUT_EN
    wait_d      = wait_q;
    err_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (io.mem_req_i) begin
          state_d     = BUS_MEM;
          bus_req_d   = 1'b1;
          bus_we_d    = io.mem_we_i;
          bus_sel_d   = io.mem_sel_i;
          bus_addr_d  = io.mem_addr_i;
          bus_wdata_d = io.mem_wdata_i;
`ifdef ARB_TIMEOUT_EN
          wait_d      = '0;
`endif
        end else if (io.if_req_i) begin
          state_d    = BUS_IF;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_sel_d  = 4'hF;
          bus_addr_d = io.if_addr_i;
`ifdef ARB_TIMEOUT_EN
          wait_d     = '0;
`endif
        end
      end
      BUS_IF, BUS_MEM: begin
        if (io.bus_ack_i) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          if (owner_if) begin
            if_ack_d  = 1'b1;
            if_data_d = io.bus_rdata_i;
          end else begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = io.bus_rdata_i;
          end
        end
`ifdef ARB_TIMEOUT_EN
        // Abort on the edge where the wait count would reach TIMEOUT.
        else if (wait_q == WAIT_LAST) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          err_d     = 1'b1;
          if (owner_if) begin
            if_ack_d  = 1'b1;
            if_data_d = '0;
          end else begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = '0;
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
`ifdef ARB_TIMEOUT_EN
      wait_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
`ifdef ARB_TIMEOUT_EN
      wait_q      <= wait_d;
      err_q       <= err_d;
`endif
    end
  end

`ifdef ARB_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign io.bus_req_o   = bus_req_q;
  assign io.bus_we_o    = bus_we_q;
  assign io.bus_sel_o   = bus_sel_q;
  assign io.bus_addr_o  = bus_addr_q;
  assign io.bus_wdata_o = bus_wdata_q;
  assign io.if_ack_o    = if_ack_q;
  assign io.mem_ack_o   = mem_ack_q;
  assign io.if_data_o   = if_data_q;
  assign io.mem_rdata_o = mem_rdata_q;

  // Pipeline stall vector: MEM access freezes pc..mem, fetch freezes pc/if.
  always_comb begin
    stall_o = 6'b000000;
    if (!rst)
      stall_o = 6'b000000;
    else if (io.mem_req_i && !mem_ack_q)
      stall_o = 6'b011111;
    else if (io.if_req_i && !if_ack_q)
      stall_o = 6'b000011;
  end

endmodule
